// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the mode-0 SPI responder
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slave_state_t;

  localparam int SYNC_STAGES    = 2;
  localparam int CLK_FREQ       = 50_000_000;
  localparam int SCLK_MIN_PHASE = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-0 SPI responder, pins oversampled in the CLOCK_50 domain
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TX = 8'hAA
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             SCLK,
  input  logic             SS_N,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  logic                   w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk  (CLOCK_50),
    .i_rst_n(RESET_N),
    .i_d    (SCLK),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // SS_N resets low so a select already asserted at reset release never starts a frame.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .i_clk  (CLOCK_50),
    .i_rst_n(RESET_N),
    .i_d    (SS_N),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  spi_slave_state_t r_state;
  logic [WIDTH-1:0] r_tx_shreg, r_rx_shreg, r_hold, r_rx_data;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_full, r_miso, r_miso_oe, r_rx_valid, r_frame_err;

  logic [WIDTH-1:0] w_load;
  logic [CW-1:0]    w_cnt_eff;
  logic             w_byte_done, w_reload, w_wr;

  assign w_load      = r_full ? r_hold : DEFAULT_TX;
  assign w_byte_done = (r_state == SHIFT) && w_sclk_rise && (r_bit_cnt == CW'(WIDTH - 1));
  assign w_reload    = ((r_state == IDLE) && w_ss_fall) || w_byte_done;
  assign w_wr        = tx_valid && !r_full;
  // Bit count after any same-cycle rise, so a closing byte is not flagged as a frame error.
  assign w_cnt_eff   = w_byte_done ? '0 : (w_sclk_rise ? r_bit_cnt + CW'(1) : r_bit_cnt);

  // A write can only land while empty, so a coincident reload has already taken DEFAULT_TX.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hold <= '0;
      r_full <= 1'b0;
    end else if (w_wr) begin
      r_hold <= tx_data;
      r_full <= 1'b1;
    end else if (w_reload) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_tx_shreg  <= '0;
      r_rx_shreg  <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_miso     <= w_load[WIDTH-1];
            r_tx_shreg <= w_load << 1;
            r_bit_cnt  <= '0;
            r_miso_oe  <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_sclk_rise) begin
            r_rx_shreg <= {r_rx_shreg[WIDTH-2:0], w_mosi};
            r_bit_cnt  <= w_cnt_eff;
            if (w_byte_done) begin
              r_rx_data  <= {r_rx_shreg[WIDTH-2:0], w_mosi};
              r_rx_valid <= 1'b1;
              r_tx_shreg <= w_load;
            end
          end
          if (w_sclk_fall) begin
            r_miso     <= r_tx_shreg[WIDTH-1];
            r_tx_shreg <= {r_tx_shreg[WIDTH-2:0], 1'b0};
          end
          if (w_ss_rise) begin
            r_state     <= IDLE;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_frame_err <= (w_cnt_eff != '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MISO      = r_miso;
  assign MISO_OE   = r_miso_oe;
  assign tx_ready  = !r_full;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed scoreboard bench for spi_slave
module tb_spi_slave;
  import spi_pkg::*;

  localparam int PHASE = CLK_FREQ / 1_000_000;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b1;
  logic       SCLK     = 1'b0;
  logic       SS_N     = 1'b1;
  logic       MOSI     = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       MISO, MISO_OE, tx_ready, rx_valid, frame_err, busy;
  logic [7:0] rx_data;

  spi_slave #(.WIDTH(8), .DEFAULT_TX(8'hAA)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .SCLK     (SCLK),
    .SS_N     (SS_N),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_OE  (MISO_OE),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int passes = 0;
  int n_rxv  = 0;
  int n_ferr = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (rx_valid === 1'b1) begin
      n_rxv++;
      chk("rx_expected", 32'(exp_rx.size() > 0), 1);
      if (exp_rx.size() > 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    if (frame_err === 1'b1) n_ferr++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic tx_write(input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 100) begin
      @(negedge CLOCK_50);
      t++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic sclk_bit(input logic b, output logic m, input logic wr, input logic [7:0] wr_b);
    MOSI = b;
    wait_cyc(PHASE);
    SCLK = 1'b1;
    m = MISO;
    if (wr) begin
      wait_cyc(2);
      tx_data  = wr_b;
      tx_valid = 1'b1;
      wait_cyc(1);
      tx_valid = 1'b0;
      chk("rx_valid_at_reload", 32'(rx_valid), 1);
      chk("tx_ready_after_wr", 32'(tx_ready), 0);
      wait_cyc(PHASE - 3);
    end else begin
      wait_cyc(PHASE);
    end
    SCLK = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input logic wr, input logic [7:0] wr_b);
    logic [7:0] mi;
    logic       m;
    exp_rx.push_back(mo);
    for (int i = 7; i >= 0; i--) begin
      sclk_bit(mo[i], m, wr && (i == 0), wr_b);
      mi[i] = m;
    end
    chk("miso_expected", 32'(exp_miso.size() > 0), 1);
    if (exp_miso.size() > 0) chk("miso_byte", 32'(mi), 32'(exp_miso.pop_front()));
  endtask

  task automatic ss_low();
    SS_N = 1'b0;
    wait_cyc(SCLK_MIN_PHASE);
  endtask

  task automatic ss_high();
    wait_cyc(PHASE);
    SS_N = 1'b1;
    wait_cyc(PHASE);
  endtask

  initial begin
    logic m;
    #5 RESET_N = 1'b0;
    wait_cyc(5);
    RESET_N = 1'b1;
    wait_cyc(5);
    chk("rst_miso", 32'(MISO), 0);
    chk("rst_miso_oe", 32'(MISO_OE), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);

    // preloaded 0xAA, master sends 0x55
    tx_write(8'hAA);
    chk("tx_ready_full", 32'(tx_ready), 0);
    exp_miso.push_back(8'hAA);
    ss_low();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_miso_oe", 32'(MISO_OE), 1);
    chk("t1_miso_first", 32'(MISO), 1);
    xfer_byte(8'h55, 1'b0, 8'h00);
    ss_high();
    chk("t1_rxv_count", 32'(n_rxv), 1);
    chk("t1_idle_oe", 32'(MISO_OE), 0);

    // empty holding register, default byte goes out
    chk("t2_tx_ready", 32'(tx_ready), 1);
    exp_miso.push_back(8'hAA);
    ss_low();
    xfer_byte(8'h3C, 1'b0, 8'h00);
    ss_high();
    chk("t2_rxv_count", 32'(n_rxv), 2);

    // two-byte frame from holding register
    tx_write(8'h12);
    exp_miso.push_back(8'h12);
    exp_miso.push_back(8'h34);
    ss_low();
    tx_write(8'h34);
    xfer_byte(8'hC5, 1'b0, 8'h00);
    xfer_byte(8'h7E, 1'b0, 8'h00);
    ss_high();
    chk("t3_rxv_count", 32'(n_rxv), 4);

    // truncated frame after 5 rises
    ss_low();
    for (int i = 0; i < 5; i++) sclk_bit(i[0], m, 1'b0, 8'h00);
    SS_N = 1'b1;
    wait_cyc(4);
    chk("t4_miso_oe", 32'(MISO_OE), 0);
    chk("t4_busy", 32'(busy), 0);
    wait_cyc(PHASE);
    chk("t4_ferr_count", 32'(n_ferr), 1);
    chk("t4_rxv_count", 32'(n_rxv), 4);

    // reset mid-frame with SS_N held low
    ss_low();
    for (int i = 0; i < 3; i++) sclk_bit(1'b1, m, 1'b0, 8'h00);
    SCLK = 1'b1;
    wait_cyc(5);
    RESET_N = 1'b0;
    #1;
    chk("t5_async_oe", 32'(MISO_OE), 0);
    wait_cyc(3);
    SCLK = 1'b0;
    RESET_N = 1'b1;
    wait_cyc(3);
    chk("t5_rst_miso", 32'(MISO), 0);
    chk("t5_rst_rx_data", 32'(rx_data), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_tx_ready", 32'(tx_ready), 1);
    for (int i = 0; i < 8; i++) sclk_bit(1'b1, m, 1'b0, 8'h00);
    chk("t5_no_rxv", 32'(n_rxv), 4);
    chk("t5_still_idle", 32'(busy), 0);
    chk("t5_oe_low", 32'(MISO_OE), 0);
    ss_high();
    exp_miso.push_back(8'hAA);
    ss_low();
    xfer_byte(8'hC3, 1'b0, 8'h00);
    ss_high();
    chk("t5_rxv_count", 32'(n_rxv), 5);
    chk("t5_ferr_count", 32'(n_ferr), 1);

    // write coincident with byte-boundary reload
    exp_miso.push_back(8'hAA);
    exp_miso.push_back(8'hAA);
    exp_miso.push_back(8'h5A);
    ss_low();
    xfer_byte(8'h01, 1'b1, 8'h5A);
    xfer_byte(8'h02, 1'b0, 8'h00);
    xfer_byte(8'h03, 1'b0, 8'h00);
    ss_high();
    chk("t6_rxv_count", 32'(n_rxv), 8);
    chk("t6_tx_ready", 32'(tx_ready), 1);

    chk("rx_queue_empty", 32'(exp_rx.size()), 0);
    chk("miso_queue_empty", 32'(exp_miso.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
